mcu_dmem_ctrl: RTL and testbench

//  Data-memory/MMIO responder directly downstream of the MCU load/store unit's dmem_req/dmem_resp port.

---
 rtl/mcu_dmem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mcu_dmem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_dmem_ctrl.sv
// Data-memory / MMIO responder behind the LSU dmem port: local byte-writable SRAM plus a
// valid/ready MMIO bridge with a posted-write FIFO, read timeout and a registered fault strobe.
module mcu_dmem_ctrl #(
   parameter int unsigned SRAM_WORDS = 4096,
   parameter logic [31:0] SRAM_BASE  = 32'h0000_0000,
   parameter logic [3:0]  MMIO_NIB   = 4'h4,
   parameter int unsigned WBUF_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dmem_req_valid,
   input  logic        dmem_req_write,
   input  logic [31:0] dmem_req_addr,
   input  logic [31:0] dmem_req_wdata,
   input  logic [3:0]  dmem_req_wstrb,
   output logic        dmem_resp_valid,
   output logic [31:0] dmem_resp_rdata,
   output logic        mmio_req_valid,
   input  logic        mmio_req_ready,
   output logic        mmio_req_write,
   output logic [31:0] mmio_req_addr,
   output logic [31:0] mmio_req_wdata,
   output logic [3:0]  mmio_req_wstrb,
   input  logic        mmio_resp_valid,
   input  logic [31:0] mmio_resp_rdata,
   output logic        err_valid,
   output logic [1:0]  err_code,
   output logic [31:0] err_addr
);

   localparam int unsigned IDX_W       = $clog2(SRAM_WORDS);
   localparam int unsigned PTR_W       = $clog2(WBUF_DEPTH) + 1;
   localparam int unsigned AW          = PTR_W - 1;
   localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

   localparam logic [1:0] ERR_UNMAPPED = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_OVERFLOW = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StSResp, StMDrain, StMReq, StMWait, StResp
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_valid_q, err_valid_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [31:0] err_addr_q, err_addr_d;

   // ---------------- address decode (only acted on in StIdle) ----------------
   logic [31:2]      sram_off;
   logic [IDX_W-1:0] sram_idx;
   logic             sram_hit, mmio_hit, req_idle;

   assign sram_off = dmem_req_addr[31:2] - SRAM_BASE[31:2];
   assign sram_idx = sram_off[IDX_W+1:2];
   assign sram_hit = (sram_off[31:IDX_W+2] == '0);
   assign mmio_hit = !sram_hit && (dmem_req_addr[31:28] == MMIO_NIB);
   assign req_idle = dmem_req_valid && (state_q == StIdle);

   // ---------------- data SRAM (contents not reset) ----------------
   logic [31:0] mem [SRAM_WORDS];
   logic [31:0] sram_rdata_q;

   always_ff @(posedge clk) begin
      if (req_idle && sram_hit) begin
         if (dmem_req_write) begin
            for (int b = 0; b < 4; b++) begin
               if (dmem_req_wstrb[b]) mem[sram_idx][8*b +: 8] <= dmem_req_wdata[8*b +: 8];
            end
         end else begin
            sram_rdata_q <= mem[sram_idx];
         end
      end
   end

   // ---------------- posted MMIO write buffer ----------------
   logic [31:0]      wb_addr [WBUF_DEPTH];
   logic [31:0]      wb_data [WBUF_DEPTH];
   logic [3:0]       wb_strb [WBUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic             wb_empty, wb_full, wb_drive, wb_pop, wb_push, mmio_wr_req;

   assign wb_empty    = (wr_ptr_q == rd_ptr_q);
   assign wb_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // The read owns the bus from StMReq until its response, so the FIFO stays quiet then.
   assign wb_drive    = !wb_empty && (state_q != StMReq) && (state_q != StMWait);
   assign wb_pop      = wb_drive && mmio_req_ready;
   assign mmio_wr_req = req_idle && dmem_req_write && mmio_hit;
   assign wb_push     = mmio_wr_req && (!wb_full || wb_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wb_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (wb_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wb_push) begin
         wb_addr[wr_ptr_q[AW-1:0]] <= dmem_req_addr;
         wb_data[wr_ptr_q[AW-1:0]] <= dmem_req_wdata;
         wb_strb[wr_ptr_q[AW-1:0]] <= dmem_req_wstrb;
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rd_addr_q   <= '0;
         resp_data_q <= '0;
         cnt_q       <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         resp_data_q <= resp_data_d;
         cnt_q       <= cnt_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         err_addr_q  <= err_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      resp_data_d = resp_data_q;
      cnt_d       = cnt_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      err_addr_d  = err_addr_q;
      unique case (state_q)
         StIdle: begin
            if (dmem_req_valid) begin
               if (dmem_req_write) begin
                  if (mmio_hit && wb_full && !wb_pop) begin
                     err_valid_d = 1'b1;
                     err_code_d  = ERR_OVERFLOW;
                     err_addr_d  = dmem_req_addr;
                  end else if (!sram_hit && !mmio_hit) begin
                     err_valid_d = 1'b1;
                     err_code_d  = ERR_UNMAPPED;
                     err_addr_d  = dmem_req_addr;
                  end
               end else if (sram_hit) begin
                  state_d = StSResp;
               end else if (mmio_hit) begin
                  rd_addr_d = dmem_req_addr;
                  state_d   = wb_empty ? StMReq : StMDrain;
               end else begin
                  resp_data_d = '0;
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_UNMAPPED;
                  err_addr_d  = dmem_req_addr;
                  state_d     = StResp;
               end
            end
         end
         StSResp:  state_d = StIdle;
         StMDrain: if (wb_empty) state_d = StMReq;
         StMReq: begin
            if (mmio_req_ready) begin
               state_d = StMWait;
               cnt_d   = '0;
            end
         end
         StMWait: begin
            if (mmio_resp_valid) begin
               resp_data_d = mmio_resp_rdata;
               state_d     = StResp;
            end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
               resp_data_d = 32'hDEAD_BEEF;
               err_valid_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
               err_addr_d  = rd_addr_q;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      dmem_resp_valid = (state_q == StSResp) || (state_q == StResp);
      dmem_resp_rdata = '0;
      if (state_q == StSResp)     dmem_resp_rdata = sram_rdata_q;
      else if (state_q == StResp) dmem_resp_rdata = resp_data_q;
   end

   always_comb begin
      mmio_req_valid = 1'b0;
      mmio_req_write = 1'b0;
      mmio_req_addr  = '0;
      mmio_req_wdata = '0;
      mmio_req_wstrb = '0;
      if (state_q == StMReq) begin
         mmio_req_valid = 1'b1;
         mmio_req_addr  = rd_addr_q;
      end else if (wb_drive) begin
         mmio_req_valid = 1'b1;
         mmio_req_write = 1'b1;
         mmio_req_addr  = wb_addr[rd_ptr_q[AW-1:0]];
         mmio_req_wdata = wb_data[rd_ptr_q[AW-1:0]];
         mmio_req_wstrb = wb_strb[rd_ptr_q[AW-1:0]];
      end
   end

   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mcu_dmem_ctrl.sv
// Directed self-checking bench for mcu_dmem_ctrl: SRAM word/byte access, posted-write overflow,
// write-before-read ordering, MMIO read timeout, unmapped accesses and mid-transaction reset.
module tb_mcu_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmem_req_valid, dmem_req_write;
   logic [31:0] dmem_req_addr, dmem_req_wdata;
   logic [3:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [31:0] dmem_resp_rdata;
   logic        mmio_req_valid, mmio_req_ready, mmio_req_write;
   logic [31:0] mmio_req_addr, mmio_req_wdata;
   logic [3:0]  mmio_req_wstrb;
   logic        mmio_resp_valid;
   logic [31:0] mmio_resp_rdata;
   logic        err_valid;
   logic [1:0]  err_code;
   logic [31:0] err_addr;

   mcu_dmem_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_write  (dmem_req_write),
      .dmem_req_addr   (dmem_req_addr),
      .dmem_req_wdata  (dmem_req_wdata),
      .dmem_req_wstrb  (dmem_req_wstrb),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_rdata (dmem_resp_rdata),
      .mmio_req_valid  (mmio_req_valid),
      .mmio_req_ready  (mmio_req_ready),
      .mmio_req_write  (mmio_req_write),
      .mmio_req_addr   (mmio_req_addr),
      .mmio_req_wdata  (mmio_req_wdata),
      .mmio_req_wstrb  (mmio_req_wstrb),
      .mmio_resp_valid (mmio_resp_valid),
      .mmio_resp_rdata (mmio_resp_rdata),
      .err_valid       (err_valid),
      .err_code        (err_code),
      .err_addr        (err_addr)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // MMIO bus model: logs handshakes, answers reads after rsp_delay cycles when rsp_en.
   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } bus_t;

   bus_t        log_q[$];
   logic        rsp_en = 1'b0;
   int unsigned rsp_delay = 1;
   logic [31:0] rsp_data = '0;
   int unsigned hs_cyc = 0, mresp_cyc = 0;

   initial begin
      logic        pend;
      int unsigned pcnt;
      pend = 1'b0;
      pcnt = 0;
      mmio_resp_valid = 1'b0;
      mmio_resp_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mmio_req_valid && mmio_req_ready) begin
            log_q.push_back('{mmio_req_write, mmio_req_addr, mmio_req_wdata, mmio_req_wstrb});
            if (!mmio_req_write) begin
               hs_cyc = cyc;
               if (rsp_en) begin
                  pend = 1'b1;
                  pcnt = rsp_delay;
               end
            end
         end
         if (mmio_resp_valid) mresp_cyc = cyc;
         @(posedge clk);
         #2;
         mmio_resp_valid = 1'b0;
         if (pend) begin
            if (pcnt <= 1) begin
               mmio_resp_valid = 1'b1;
               mmio_resp_rdata = rsp_data;
               pend = 1'b0;
            end else begin
               pcnt--;
            end
         end
      end
   end

   // Results of the last do_read.
   logic        r_ok, r_after;
   logic [31:0] r_data, r_eaddr;
   logic [2:0]  r_err;
   int unsigned r_cyc, r_lat;

   // All tasks start and end 2 time units after a rising edge.
   task automatic dmem_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
      dmem_req_valid = 1'b1;
      dmem_req_write = 1'b1;
      dmem_req_addr  = addr;
      dmem_req_wdata = data;
      dmem_req_wstrb = strb;
      @(posedge clk);
      #2;
      dmem_req_valid = 1'b0;
      dmem_req_write = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr);
      int unsigned c0;
      c0      = cyc;
      r_ok    = 1'b0;
      r_data  = '0;
      r_err   = '0;
      r_eaddr = '0;
      r_cyc   = 0;
      r_lat   = 0;
      dmem_req_valid = 1'b1;
      dmem_req_write = 1'b0;
      dmem_req_addr  = addr;
      dmem_req_wstrb = 4'h0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (dmem_resp_valid) begin
            r_ok    = 1'b1;
            r_data  = dmem_resp_rdata;
            r_err   = {err_valid, err_code};
            r_eaddr = err_addr;
            r_cyc   = cyc;
            r_lat   = cyc - c0;
            break;
         end
      end
      @(posedge clk);
      #2;
      dmem_req_valid = 1'b0;
      @(negedge clk);
      r_after = dmem_resp_valid;
      @(posedge clk);
      #2;
   endtask

   task automatic check_quiet_outs(input string tag);
      check({tag, "_ctl"}, 32'({dmem_resp_valid, mmio_req_valid, mmio_req_write, err_valid,
                                err_code}), 32'h0);
      check({tag, "_rdata"}, dmem_resp_rdata, 32'h0);
      check({tag, "_maddr"}, mmio_req_addr | mmio_req_wdata | 32'(mmio_req_wstrb), 32'h0);
      check({tag, "_eaddr"}, err_addr, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned base;
      int unsigned n;
      rst_n          = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_req_write = 1'b0;
      dmem_req_addr  = '0;
      dmem_req_wdata = '0;
      dmem_req_wstrb = '0;
      mmio_req_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet_outs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Full-word SRAM store then load: response exactly one cycle after the request.
      dmem_write(32'h0000_0010, 32'h1234_5678, 4'hF);
      do_read(32'h0000_0010);
      check("sw_lw_ok", 32'(r_ok), 32'd1);
      check("sw_lw_lat", r_lat, 32'd1);
      check("sw_lw_data", r_data, 32'h1234_5678);
      check("sw_lw_pulse", 32'(r_after), 32'd0);
      check("sw_lw_noerr", 32'(r_err), 32'd0);

      // Byte store into lane 1.
      dmem_write(32'h0000_0010, 32'h0000_AB00, 4'b0010);
      do_read(32'h0000_0010);
      check("sb_data", r_data, 32'h1234_AB78);

      // Five posted writes with the bus stalled: four queue, the fifth overflows.
      base = log_q.size();
      for (int i = 0; i < 5; i++) begin
         dmem_req_valid = 1'b1;
         dmem_req_write = 1'b1;
         dmem_req_addr  = 32'h4000_0100 + 32'(4 * i);
         dmem_req_wdata = 32'hA0 + 32'(i);
         dmem_req_wstrb = 4'hF;
         @(posedge clk);
         #1;
         if (i < 4) begin
            check($sformatf("ovf_noerr%0d", i), 32'(err_valid), 32'd0);
         end else begin
            check("ovf_err", 32'({err_valid, err_code}), 32'b111);
            check("ovf_eaddr", err_addr, 32'h4000_0110);
         end
         #1;
      end
      dmem_req_valid = 1'b0;
      dmem_req_write = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ovf_head", 32'({mmio_req_valid, mmio_req_write}), 32'b11);
      check("ovf_head_addr", mmio_req_addr, 32'h4000_0100);
      check("ovf_stalled", log_q.size() - base, 32'd0);
      @(posedge clk);
      #2;
      mmio_req_ready = 1'b1;
      repeat (8) @(posedge clk);
      #2;
      check("ovf_drain_cnt", log_q.size() - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < log_q.size()) begin
            check($sformatf("ovf_wr%0d_addr", i), log_q[base+i].a, 32'h4000_0100 + 32'(4 * i));
            check($sformatf("ovf_wr%0d_data", i), log_q[base+i].d, 32'hA0 + 32'(i));
         end
      end
      @(negedge clk);
      check("ovf_empty", 32'(mmio_req_valid), 32'd0);
      @(posedge clk);
      #2;

      // Posted write immediately followed by an MMIO read: the write goes out first.
      rsp_en    = 1'b1;
      rsp_delay = 1;
      rsp_data  = 32'hCAFE_0001;
      base      = log_q.size();
      dmem_write(32'h4000_0000, 32'h0000_0011, 4'hF);
      do_read(32'h4000_0004);
      check("ord_ok", 32'(r_ok), 32'd1);
      check("ord_data", r_data, 32'hCAFE_0001);
      check("ord_lat", r_cyc - mresp_cyc, 32'd1);
      check("ord_cnt", log_q.size() - base, 32'd2);
      if (log_q.size() - base >= 2) begin
         check("ord_first", 32'({log_q[base].w, log_q[base].s}), 32'h1F);
         check("ord_first_addr", log_q[base].a, 32'h4000_0000);
         check("ord_first_data", log_q[base].d, 32'h0000_0011);
         check("ord_second", 32'({log_q[base+1].w, log_q[base+1].s}), 32'h00);
         check("ord_second_addr", log_q[base+1].a, 32'h4000_0004);
      end

      // MMIO read with no response: 255 cycles in the wait state, then DEADBEEF + timeout.
      rsp_en = 1'b0;
      do_read(32'h4000_0008);
      check("to_ok", 32'(r_ok), 32'd1);
      check("to_data", r_data, 32'hDEAD_BEEF);
      check("to_err", 32'(r_err), 32'b110);
      check("to_eaddr", r_eaddr, 32'h4000_0008);
      check("to_lat", r_cyc - hs_cyc, 32'd256);
      check("to_pulse", 32'(r_after), 32'd0);

      // Unmapped load and store.
      do_read(32'h7000_0000);
      check("um_rd_lat", r_lat, 32'd1);
      check("um_rd_data", r_data, 32'h0);
      check("um_rd_err", 32'(r_err), 32'b101);
      check("um_rd_eaddr", r_eaddr, 32'h7000_0000);
      dmem_write(32'h7000_0010, 32'hFFFF_FFFF, 4'hF);
      @(negedge clk);
      check("um_wr_err", 32'({err_valid, err_code}), 32'b101);
      check("um_wr_eaddr", err_addr, 32'h7000_0010);
      @(negedge clk);
      check("um_wr_once", 32'(err_valid), 32'd0);
      @(posedge clk);
      #2;

      // Reset while waiting on an MMIO read: outputs drop at once and no response follows.
      dmem_req_valid = 1'b1;
      dmem_req_write = 1'b0;
      dmem_req_addr  = 32'h4000_000C;
      repeat (5) @(posedge clk);
      #2;
      dmem_req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_quiet_outs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (dmem_resp_valid || err_valid) n++;
      end
      check("midrst_noresp", n, 32'd0);
      @(posedge clk);
      #2;

      // SRAM contents survive reset.
      do_read(32'h0000_0010);
      check("post_rst_data", r_data, 32'h1234_AB78);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
